prio_encoder_rr: RTL and testbench

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

---
 rtl/enc_pkg.sv | 15 +
 rtl/prio_pick.sv | 35 +++
 rtl/prio_encoder_rr.sv | 76 +++++++
 tb/tb_prio_encoder_rr.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants and helpers for the priority encoder
package enc_pkg;

   localparam int ENC_FIXED = 0;
   localparam int ENC_RR    = 1;

   // Index width for n requests; n is at least 2, so the result is never 0.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational lowest/highest set-bit finder
module prio_pick
   import enc_pkg::*;
#(
   parameter int  N    = 8,
   parameter bit  HIGH = 1'b0,
   localparam int W    = clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic         found,
   output logic [W-1:0] idx
);

   // The last match written wins, so the scan direction picks the extreme bit.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      if (HIGH) begin
         for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
               found = 1'b1;
               idx   = W'(i);
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
               found = 1'b1;
               idx   = W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered fixed/round-robin priority encoder with valid/ready output
module prio_encoder_rr
   import enc_pkg::*;
#(
   parameter int  N    = 8,
   parameter int  MODE = ENC_FIXED,
   localparam int W    = clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] in,
   input  logic         ready,
   output logic [W-1:0] out,
   output logic         valid,
   output logic         multi
);

   logic [W-1:0] ptr;
   logic [W-1:0] ptr_nxt;
   logic [W-1:0] sel;
   logic [N-1:0] masked;
   logic         any;
   logic         load;
   logic         is_multi;

   always_comb begin
      masked = '0;
      for (int i = 0; i < N; i++) begin
         masked[i] = in[i] && (i >= int'(ptr));
      end
   end

   generate
      if (MODE == ENC_RR) begin : g_rr
         logic         found_m;
         logic         found_u;
         logic [W-1:0] idx_m;
         logic [W-1:0] idx_u;

         prio_pick #(.N(N), .HIGH(1'b0)) u_masked (.vec(masked), .found(found_m), .idx(idx_m));
         prio_pick #(.N(N), .HIGH(1'b0)) u_raw    (.vec(in),     .found(found_u), .idx(idx_u));

         assign any = found_u;
         assign sel = found_m ? idx_m : idx_u;
      end else begin : g_fixed
         // ptr is held at 0 here, so the masked vector equals in.
         prio_pick #(.N(N), .HIGH(1'b1)) u_fixed (.vec(masked), .found(any), .idx(sel));
      end
   endgenerate

   assign load     = en && (!valid || ready);
   assign is_multi = (in & (in - 1'b1)) != '0;
   assign ptr_nxt  = (sel == W'(N - 1)) ? '0 : sel + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out   <= '0;
         valid <= 1'b0;
         multi <= 1'b0;
         ptr   <= '0;
      end else if (load) begin
         if (any) begin
            out   <= sel;
            multi <= is_multi;
            valid <= 1'b1;
            if (MODE == ENC_RR) ptr <= ptr_nxt;
         end else begin
            valid <= 1'b0;
         end
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - scoreboard bench for fixed (N=8, N=5) and round-robin (N=8) encoders
module tb_prio_encoder_rr;
   import enc_pkg::*;

   typedef struct {
      int out;
      int multi;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   logic       en_a, ready_a, valid_a, multi_a;
   logic [7:0] in_a;
   logic [2:0] out_a;
   logic       en_b, ready_b, valid_b, multi_b;
   logic [7:0] in_b;
   logic [2:0] out_b;
   logic       en_c, ready_c, valid_c, multi_c;
   logic [4:0] in_c;
   logic [2:0] out_c;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prio_encoder_rr #(.N(8), .MODE(ENC_FIXED)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .in(in_a), .ready(ready_a),
      .out(out_a), .valid(valid_a), .multi(multi_a));

   prio_encoder_rr #(.N(8), .MODE(ENC_RR)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .in(in_b), .ready(ready_b),
      .out(out_b), .valid(valid_b), .multi(multi_b));

   prio_encoder_rr #(.N(5), .MODE(ENC_FIXED)) dut_c (
      .clk(clk), .rst_n(rst_n), .en(en_c), .in(in_c), .ready(ready_c),
      .out(out_c), .valid(valid_c), .multi(multi_c));

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input string name, inout exp_t q[$], input int o, input int m);
      exp_t e;
      if (q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s unexpected result: got out %0d multi %0d expected none", name, o, m);
      end else begin
         e = q.pop_front();
         check({name, " out"}, o, e.out);
         check({name, " multi"}, m, e.multi);
      end
   endtask

   // Monitor: a result is consumed on the edge where valid and ready are both high.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (valid_a && ready_a) pop_cmp("fix8", q_a, int'(out_a), int'(multi_a));
         if (valid_b && ready_b) pop_cmp("rr8",  q_b, int'(out_b), int'(multi_b));
         if (valid_c && ready_c) pop_cmp("fix5", q_c, int'(out_c), int'(multi_c));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      en_a = 0; ready_a = 0; in_a = '0;
      en_b = 0; ready_b = 0; in_b = '0;
      en_c = 0; ready_c = 0; in_c = '0;
      step();
      step();
      check("reset out_a", int'(out_a), 0);
      check("reset valid_a", int'(valid_a), 0);
      check("reset valid_b", int'(valid_b), 0);
      check("reset valid_c", int'(valid_c), 0);
      rst_n = 1'b1;

      // Async reset in the middle of a held result.
      en_a = 1; ready_a = 0; in_a = 8'h20;
      step();
      en_a = 0;
      check("pre-reset out", int'(out_a), 5);
      check("pre-reset valid", int'(valid_a), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset out", int'(out_a), 0);
      check("async reset valid", int'(valid_a), 0);
      check("async reset multi", int'(multi_a), 0);
      step();
      rst_n = 1'b1;

      // Fixed priority: highest bit wins, then zero input clears valid.
      en_a = 1; ready_a = 1; in_a = 8'b0100_1000;
      q_a.push_back('{6, 1});
      step();
      in_a = '0;
      step();
      check("zero-in valid", int'(valid_a), 0);
      check("zero-in out hold", int'(out_a), 6);
      check("zero-in multi hold", int'(multi_a), 1);

      // Backpressure holds the result, then accept plus reload without a bubble.
      ready_a = 0; in_a = 8'h08;
      q_a.push_back('{3, 0});
      step();
      in_a = 8'h01;
      step();
      check("stall out", int'(out_a), 3);
      check("stall valid", int'(valid_a), 1);
      ready_a = 1;
      q_a.push_back('{0, 0});
      step();
      check("no bubble valid", int'(valid_a), 1);
      en_a = 0;
      step();
      check("drained valid", int'(valid_a), 0);

      // One-hot vectors encode to their bit position, back to back.
      en_a = 1;
      for (int k = 0; k < 8; k++) begin
         in_a = 8'(1 << k);
         q_a.push_back('{k, 0});
         step();
      end
      en_a = 0;
      step();

      // Round robin over all requests, wrapping 7 -> 0.
      en_b = 1; ready_b = 1; in_b = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         q_b.push_back('{k % 8, 1});
         step();
      end
      in_b = 8'h20;
      q_b.push_back('{5, 0});
      step();
      in_b = 8'h21;
      q_b.push_back('{0, 1});
      q_b.push_back('{5, 1});
      step();
      step();
      en_b = 0;
      step();

      // Non-power-of-two width.
      en_c = 1; ready_c = 1;
      in_c = 5'b10000; q_c.push_back('{4, 0}); step();
      in_c = 5'b00011; q_c.push_back('{1, 1}); step();
      in_c = 5'b11111; q_c.push_back('{4, 1}); step();
      en_c = 0;
      step();
      step();

      check("fix8 queue drained", q_a.size(), 0);
      check("rr8 queue drained", q_b.size(), 0);
      check("fix5 queue drained", q_c.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
